// File: rtl/scan_frame_sequencer.sv
// Scan-frame sequencer: produces scan_en, clk_scan and load_gold_n for the scan-chain core
// from the system clock. Every output is a flop loaded from the next-state logic.
module scan_frame_sequencer #(
    parameter int unsigned SCAN_LEN    = 8,
    parameter int unsigned HALF_PER    = 1,
    parameter int unsigned GOLD_CYCLES = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              gold_req,
    input  logic                              abort,
    output logic                              scan_en,
    output logic                              clk_scan,
    output logic                              load_gold_n,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(SCAN_LEN+1)-1:0]     bit_cnt
);

    localparam int unsigned BW = $clog2(SCAN_LEN + 1);
    localparam int unsigned PW = $clog2(HALF_PER + 1);
    localparam int unsigned GW = $clog2(GOLD_CYCLES + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(SCAN_LEN);
    localparam logic [PW-1:0] PH_LAST   = PW'(HALF_PER - 1);
    localparam logic [GW-1:0] GOLD_LAST = GW'(GOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GOLD  = 3'd1,
        SETUP = 3'd2,
        SHIFT = 3'd3,
        TAIL  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            scan_en_q, scan_en_d;
    logic            clk_scan_q, clk_scan_d;
    logic            load_gold_n_q, load_gold_n_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [GW-1:0]   gold_cnt_q, gold_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            scan_en_q     <= 1'b0;
            clk_scan_q    <= 1'b0;
            load_gold_n_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            bit_cnt_q     <= '0;
            phase_q       <= '0;
            gold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            scan_en_q     <= scan_en_d;
            clk_scan_q    <= clk_scan_d;
            load_gold_n_q <= load_gold_n_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            bit_cnt_q     <= bit_cnt_d;
            phase_q       <= phase_d;
            gold_cnt_q    <= gold_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        scan_en_d     = scan_en_q;
        clk_scan_d    = clk_scan_q;
        load_gold_n_d = load_gold_n_q;
        done_d        = 1'b0;
        bit_cnt_d     = bit_cnt_q;
        phase_d       = phase_q;
        gold_cnt_d    = gold_cnt_q;

        // Abort overrides every transition; bit_cnt is left showing progress so far.
        if (abort && (state_q != IDLE)) begin
            state_d       = IDLE;
            scan_en_d     = 1'b0;
            clk_scan_d    = 1'b0;
            load_gold_n_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gold_req) begin
                        state_d       = GOLD;
                        load_gold_n_d = 1'b0;
                        gold_cnt_d    = '0;
                    end else if (start) begin
                        state_d    = SETUP;
                        scan_en_d  = 1'b1;
                        clk_scan_d = 1'b0;
                        bit_cnt_d  = '0;
                    end
                end
                GOLD: begin
                    if (gold_cnt_q == GOLD_LAST) begin
                        state_d       = IDLE;
                        load_gold_n_d = 1'b1;
                        done_d        = 1'b1;
                    end else begin
                        gold_cnt_d = gold_cnt_q + GW'(1);
                    end
                end
                SETUP: begin
                    state_d    = SHIFT;
                    scan_en_d  = 1'b1;
                    clk_scan_d = 1'b0;
                    phase_d    = '0;
                end
                SHIFT: begin
                    // phase_q counts cycles already spent in the current clk_scan level.
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        if (!clk_scan_q) begin
                            clk_scan_d = 1'b1;
                            bit_cnt_d  = bit_cnt_q + BW'(1);
                        end else begin
                            clk_scan_d = 1'b0;
                            if (bit_cnt_q == BIT_LAST) begin
                                state_d = TAIL;
                            end
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
                TAIL: begin
                    state_d   = IDLE;
                    scan_en_d = 1'b0;
                    done_d    = 1'b1;
                end
                default: begin
                    state_d       = IDLE;
                    scan_en_d     = 1'b0;
                    clk_scan_d    = 1'b0;
                    load_gold_n_d = 1'b1;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign scan_en     = scan_en_q;
    assign clk_scan    = clk_scan_q;
    assign load_gold_n = load_gold_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_scan_frame_sequencer.sv
// Directed bench for scan_frame_sequencer: default instance plus a HALF_PER=2/SCAN_LEN=4 instance.
module tb_scan_frame_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic start = 1'b0, gold_req = 1'b0, abort = 1'b0;
    logic scan_en, clk_scan, load_gold_n, busy, done;
    logic [3:0] bit_cnt;

    logic start2 = 1'b0, gold2 = 1'b0, abort2 = 1'b0;
    logic scan_en2, clk_scan2, load_gold_n2, busy2, done2;
    logic [2:0] bit_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scan_frame_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .gold_req(gold_req), .abort(abort),
        .scan_en(scan_en), .clk_scan(clk_scan), .load_gold_n(load_gold_n),
        .busy(busy), .done(done), .bit_cnt(bit_cnt)
    );

    scan_frame_sequencer #(.SCAN_LEN(4), .HALF_PER(2), .GOLD_CYCLES(5)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .gold_req(gold2), .abort(abort2),
        .scan_en(scan_en2), .clk_scan(clk_scan2), .load_gold_n(load_gold_n2),
        .busy(busy2), .done(done2), .bit_cnt(bit_cnt2)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One start pulse on the default instance; cycle 1 is the first cycle after start is sampled.
    task automatic frame_run(input string p);
        int en = 0, bz = 0, hi = 0, rises = 0, first = 0, done_at = 0, dn = 0;
        logic prev = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            cyc();
            start = 1'b0;
            if (c == 1) begin
                chk({p, "_setup_en"}, int'(scan_en), 1);
                chk({p, "_setup_clk"}, int'(clk_scan), 0);
                chk({p, "_setup_cnt"}, int'(bit_cnt), 0);
            end
            if (c == 3) chk({p, "_cnt_first_rise"}, int'(bit_cnt), 1);
            if (scan_en) en++;
            if (busy) bz++;
            if (clk_scan) hi++;
            if (clk_scan && !prev) begin
                rises++;
                if (first == 0) first = c;
            end
            prev = clk_scan;
            if (done) begin
                dn++;
                done_at = c;
            end
        end
        chk({p, "_en_cycles"}, en, 18);
        chk({p, "_busy_cycles"}, bz, 18);
        chk({p, "_clk_high_cycles"}, hi, 8);
        chk({p, "_rises"}, rises, 8);
        chk({p, "_first_rise"}, first, 3);
        chk({p, "_done_cycle"}, done_at, 19);
        chk({p, "_done_count"}, dn, 1);
        chk({p, "_final_cnt"}, int'(bit_cnt), 8);
        chk({p, "_lgn_idle"}, int'(load_gold_n), 1);
    endtask

    // Gold load with start pulsed mid-load (must be ignored). Optionally start arrives with gold_req.
    task automatic gold_run(input string p, input logic with_start);
        int low = 0, first = 0, done_at = 0, en = 0;
        gold_req = 1'b1;
        start = with_start;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            gold_req = 1'b0;
            start = (c == 3);
            if (!load_gold_n) begin
                low++;
                if (first == 0) first = c;
            end
            if (done) done_at = c;
            if (scan_en) en++;
        end
        start = 1'b0;
        chk({p, "_lgn_low_cycles"}, low, 5);
        chk({p, "_lgn_first_low"}, first, 1);
        chk({p, "_done_cycle"}, done_at, 6);
        chk({p, "_scan_en_cycles"}, en, 0);
        chk({p, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int en2, first2, done2_at, rises2, dn2;
        logic prev2;

        // 1: reset held with clock running
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scan_en", int'(scan_en), 0);
        chk("rst_clk_scan", int'(clk_scan), 0);
        chk("rst_lgn", int'(load_gold_n), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bit_cnt", int'(bit_cnt), 0);
        rst = 1'b0;
        cyc();
        cyc();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_lgn", int'(load_gold_n), 1);

        // 2: default frame
        frame_run("frame");

        // abort in IDLE does nothing
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("idle_abort_busy", int'(busy), 0);
        chk("idle_abort_cnt", int'(bit_cnt), 8);
        chk("idle_abort_done", int'(done), 0);

        // 3 and 4: gold load alone, then gold_req together with start
        gold_run("gold", 1'b0);
        chk("gold_cnt_holds", int'(bit_cnt), 8);
        gold_run("gold_start", 1'b1);

        // Full frame on the HALF_PER=2, SCAN_LEN=4 instance
        en2 = 0; first2 = 0; done2_at = 0; rises2 = 0; prev2 = 1'b0;
        start2 = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            cyc();
            start2 = 1'b0;
            if (scan_en2) en2++;
            if (clk_scan2 && !prev2) begin
                rises2++;
                if (first2 == 0) first2 = c;
            end
            prev2 = clk_scan2;
            if (done2) done2_at = c;
        end
        chk("f2_en_cycles", en2, 18);
        chk("f2_rises", rises2, 4);
        chk("f2_first_rise", first2, 4);
        chk("f2_done_cycle", done2_at, 19);
        chk("f2_final_cnt", int'(bit_cnt2), 4);

        // 5: abort after the second clk_scan rise
        start2 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            start2 = 1'b0;
            if (c == 4) chk("ab_cnt_rise1", int'(bit_cnt2), 1);
            if (c == 7) chk("ab_clk_low_c7", int'(clk_scan2), 0);
        end
        chk("ab_clk_at_rise2", int'(clk_scan2), 1);
        chk("ab_cnt_at_rise2", int'(bit_cnt2), 2);
        abort2 = 1'b1;
        cyc();
        abort2 = 1'b0;
        chk("ab_clk_scan", int'(clk_scan2), 0);
        chk("ab_scan_en", int'(scan_en2), 0);
        chk("ab_busy", int'(busy2), 0);
        chk("ab_bit_cnt", int'(bit_cnt2), 2);
        dn2 = int'(done2);
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (done2) dn2++;
        end
        chk("ab_no_done", dn2, 0);
        chk("ab_cnt_holds", int'(bit_cnt2), 2);

        // 6: asynchronous reset while clk_scan is high
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("mid_clk_high", int'(clk_scan), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_clk_scan", int'(clk_scan), 0);
        chk("async_scan_en", int'(scan_en), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_bit_cnt", int'(bit_cnt), 0);
        #10;
        rst = 1'b0;
        cyc();
        chk("after_rst_busy", int'(busy), 0);
        frame_run("refr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
